cursor_overlay_pipe: RTL and testbench
======================================

// Module: cursor_overlay_pipe
// PURPOSE
//  Parametrised successor of the single-cycle mouse overlay: draws an arrow, scope (crosshair) or no cursor over the VGA stream.
//  Frame-coherent: position/mode update only at frame start, so the cursor never tears mid-frame.
//  Adds a click-flash on the scope. Sits after the last background/object stage, before VGA output registers.
// PARAMETERS
//  ARROW_H      17       arrow height: left outline column spans dy=0..ARROW_H
//  ARROW_W      12       arrow width: diagonal and base row at dy=ARROW_W
//  SCOPE_ARM    3        scope arm length in pixels
//  SCOPE_GAP    1        empty pixels between scope centre dot and arms
//  CHANGE_X     768      scope allowed only when latched xpos < CHANGE_X
//  FLASH_FRAMES 8        frames the scope shows COL_FLASH after a click
//  COL_OUTLINE  12'h000  outline/scope colour
//  COL_FILL     12'hfff  arrow fill colour
//  COL_FLASH    12'hf00  scope colour while flashing
// PORTS
//  clk                 in   1   pixel clock
//  rst                 in   1   synchronous, active-high reset
//  xpos, ypos          in   12  cursor hot-spot (pixels)
//  hcount              in   11  timing in
//  vcount              in   10  timing in
//  hsync, vsync, hblnk, vblnk  in  1  timing in
//  rgb_in              in   12  background pixel
//  select_mode         in   1   request scope mode
//  cursor_en           in   1   0 = hide cursor
//  mouse_left          in   1   left button level
//  hcount_out          out  11  timing delayed 2 clk
//  vcount_out          out  10  timing delayed 2 clk
//  hsync_out, vsync_out, hblnk_out, vblnk_out  out  1  delayed 2 clk
//  rgb_out             out  12  composited pixel
//  mode_out            out  2   active mode: 0 ARROW, 1 SCOPE, 2 HIDDEN
// BEHAVIOUR
//  Reset: all outputs 0, mode ARROW, latched pos 0, flash counter 0, click pending 0, pipeline cleared.
//  Frame boundary = cycle where vsync=1 and the previous-cycle vsync=0 (registered edge detect).
//  At boundary: latch xpos/ypos.
//    Next mode: !cursor_en -> HIDDEN; else select_mode && xpos<CHANGE_X -> SCOPE; else ARROW.
//    Decision uses current-cycle inputs. Mode and pos hold constant between boundaries.
//  Click: rising edge of mouse_left (registered) sets pending.
//    At boundary: pending -> counter=FLASH_FRAMES and clear pending; else counter-=1 if >0 (saturates at 0).
//    Edge on the boundary cycle itself is counted at that boundary.
//  Pipeline, latency 2 on every output path:
//    S1: dx = hcount - lx, dy = vcount - ly, 13-bit signed (no wrap; cursor is clipped at screen edges).
//    S1: register blank = hblnk|vblnk.
//    S2: shape decode, colour mux.
//  ARROW (dx,dy >= 0):
//    outline = dx==0 && dy<=ARROW_H
//           || dx==dy && dy<=ARROW_W
//           || dy==ARROW_W && dx>=ARROW_H-ARROW_W && dx<=ARROW_W
//           || dx+dy==ARROW_H && dx>=1 && dy>ARROW_W
//    fill = !outline && dx>=1 && dy>dx && (dy<ARROW_W || dx+dy<ARROW_H)
//    outline -> COL_OUTLINE; fill -> COL_FILL.
//  SCOPE: dot at dx=dy=0.
//    Arms: dy==0 && SCOPE_GAP<|dx|<=SCOPE_GAP+SCOPE_ARM, and same with dx/dy swapped.
//    Scope pixels -> COL_FLASH if counter>0, else COL_OUTLINE.
//  HIDDEN: rgb_out = rgb_in (delayed).
//  Any pixel with blank=1 -> rgb_in passthrough. Non-cursor pixels -> rgb_in delayed 2 clk.
//  Priority: blank > outline > fill > rgb_in.
//  Reset mid-frame: next cycle outputs 0; drawing resumes in ARROW at pos 0 until first boundary.
// TESTING
//  1. rst 1 clk, release -> all outputs 0 at cycle 1.
//     hsync pulse at hcount=5 appears on hsync_out exactly 2 clk later.
//  2. ARROW, xpos=100, ypos=50 latched:
//     (100,50)=000; (103,58)=fff; (105,62)=000; (101,66)=000; (106,50)=rgb_in.
//  3. select_mode=1, xpos=700 -> mode_out=1 after next boundary.
//     (698,Y)=000; (699,Y)=rgb_in.
//     xpos=800 -> mode_out=0 next frame.
//  4. Change xpos mid-frame 100->300 -> cursor stays at 100 until next boundary, then moves.
//  5. SCOPE, mouse_left pulse -> next 8 frames arms f00, 9th frame 000.
//     Pulse on boundary cycle -> counted in that boundary.
//  6. cursor_en=0 -> mode_out=2, rgb_out==rgb_in delayed 2.
//     Cursor at hblnk pixels -> rgb_in passthrough.

Source files
------------

// File: rtl/cursor_overlay_pipe.sv
// Two-stage cursor compositor: arrow, scope crosshair or hidden, drawn over the VGA stream.
// Cursor position and mode are latched at frame start so the cursor never tears mid-frame.
module cursor_overlay_pipe #(
    parameter int          ARROW_H      = 17,
    parameter int          ARROW_W      = 12,
    parameter int          SCOPE_ARM    = 3,
    parameter int          SCOPE_GAP    = 1,
    parameter int          CHANGE_X     = 768,
    parameter int          FLASH_FRAMES = 8,
    parameter logic [11:0] COL_OUTLINE  = 12'h000,
    parameter logic [11:0] COL_FILL     = 12'hfff,
    parameter logic [11:0] COL_FLASH    = 12'hf00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        hblnk,
    input  logic        vblnk,
    input  logic [11:0] rgb_in,
    input  logic        select_mode,
    input  logic        cursor_en,
    input  logic        mouse_left,
    output logic [10:0] hcount_out,
    output logic [9:0]  vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out,
    output logic [1:0]  mode_out
);
    localparam int CW = $clog2(FLASH_FRAMES + 1);
    localparam logic signed [12:0] AH    = 13'(ARROW_H);
    localparam logic signed [12:0] AW    = 13'(ARROW_W);
    localparam logic signed [12:0] AHW   = 13'(ARROW_H - ARROW_W);
    localparam logic signed [12:0] GAP   = 13'(SCOPE_GAP);
    localparam logic signed [12:0] REACH = 13'(SCOPE_GAP + SCOPE_ARM);
    localparam logic signed [12:0] ZERO  = 13'sd0;
    localparam logic signed [12:0] ONE   = 13'sd1;
    localparam logic [12:0]        CHG   = 13'(CHANGE_X);

    typedef enum logic [1:0] {
        MODE_ARROW  = 2'd0,
        MODE_SCOPE  = 2'd1,
        MODE_HIDDEN = 2'd2
    } mode_t;

    mode_t          mode_q, next_mode;
    logic           vsync_prev, mouse_prev, pending;
    logic [CW-1:0]  flash_cnt;
    logic [11:0]    lx, ly;
    logic           frame_start, click;

    assign frame_start = vsync & ~vsync_prev;
    assign click       = mouse_left & ~mouse_prev;
    assign mode_out    = mode_q;

    always_comb begin
        next_mode = MODE_ARROW;
        if (!cursor_en)
            next_mode = MODE_HIDDEN;
        else if (select_mode && ({1'b0, xpos} < CHG))
            next_mode = MODE_SCOPE;
    end

    // A click seen on the boundary cycle itself reloads the flash counter at that boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_prev <= 1'b0;
            mouse_prev <= 1'b0;
            pending    <= 1'b0;
            flash_cnt  <= '0;
            lx         <= '0;
            ly         <= '0;
            mode_q     <= MODE_ARROW;
        end else begin
            vsync_prev <= vsync;
            mouse_prev <= mouse_left;
            if (frame_start) begin
                lx      <= xpos;
                ly      <= ypos;
                mode_q  <= next_mode;
                pending <= 1'b0;
                if (pending || click)
                    flash_cnt <= CW'(FLASH_FRAMES);
                else if (flash_cnt != '0)
                    flash_cnt <= flash_cnt - 1'b1;
            end else if (click) begin
                pending <= 1'b1;
            end
        end
    end

    logic signed [12:0] dx_c, dy_c, dx1, dy1;
    logic               blank1, hsync1, vsync1, hblnk1, vblnk1;
    logic [10:0]        hcount1;
    logic [9:0]         vcount1;
    logic [11:0]        rgb1;

    assign dx_c = {2'b00, hcount} - {1'b0, lx};
    assign dy_c = {3'b000, vcount} - {1'b0, ly};

    always_ff @(posedge clk) begin
        if (rst) begin
            dx1 <= '0; dy1 <= '0; blank1 <= 1'b0; rgb1 <= '0;
            hcount1 <= '0; vcount1 <= '0;
            hsync1 <= 1'b0; vsync1 <= 1'b0; hblnk1 <= 1'b0; vblnk1 <= 1'b0;
        end else begin
            dx1 <= dx_c; dy1 <= dy_c; blank1 <= hblnk | vblnk; rgb1 <= rgb_in;
            hcount1 <= hcount; vcount1 <= vcount;
            hsync1 <= hsync; vsync1 <= vsync; hblnk1 <= hblnk; vblnk1 <= vblnk;
        end
    end

    logic               quad, outline, fill, scope_hit;
    logic signed [12:0] sum, adx, ady;
    logic [11:0]        pix;

    assign quad = !dx1[12] && !dy1[12];
    assign sum  = dx1 + dy1;
    assign adx  = dx1[12] ? -dx1 : dx1;
    assign ady  = dy1[12] ? -dy1 : dy1;

    assign outline = quad && ((dx1 == ZERO && dy1 <= AH)
                           || (dx1 == dy1 && dy1 <= AW)
                           || (dy1 == AW && dx1 >= AHW && dx1 <= AW)
                           || (sum == AH && dx1 >= ONE && dy1 > AW));
    assign fill = quad && !outline && dx1 >= ONE && dy1 > dx1 && (dy1 < AW || sum < AH);
    assign scope_hit = (dx1 == ZERO && dy1 == ZERO)
                    || (dy1 == ZERO && adx > GAP && adx <= REACH)
                    || (dx1 == ZERO && ady > GAP && ady <= REACH);

    always_comb begin
        pix = rgb1;
        if (!blank1) begin
            case (mode_q)
                MODE_ARROW: begin
                    if (outline)   pix = COL_OUTLINE;
                    else if (fill) pix = COL_FILL;
                end
                MODE_SCOPE: begin
                    if (scope_hit) pix = (flash_cnt != '0) ? COL_FLASH : COL_OUTLINE;
                end
                default: pix = rgb1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_out <= '0; vcount_out <= '0;
            hsync_out <= 1'b0; vsync_out <= 1'b0; hblnk_out <= 1'b0; vblnk_out <= 1'b0;
            rgb_out <= '0;
        end else begin
            hcount_out <= hcount1; vcount_out <= vcount1;
            hsync_out <= hsync1; vsync_out <= vsync1; hblnk_out <= hblnk1; vblnk_out <= vblnk1;
            rgb_out <= pix;
        end
    end
endmodule

// File: tb/tb_cursor_overlay_pipe.sv
// Randomized bench for cursor_overlay_pipe: a frame-level reference model predicts every
// output cycle; a monitor pops predictions two cycles later and compares.
module tb_cursor_overlay_pipe;
    localparam int A_H = 17, A_W = 12, ARM = 3, GAPW = 1, CHX = 768, FLASH = 8;

    logic        clk = 1'b0, rst = 1'b1;
    logic [11:0] xpos = '0, ypos = '0, rgb_in = '0;
    logic [10:0] hcount = '0;
    logic [9:0]  vcount = '0;
    logic        hsync = 0, vsync = 0, hblnk = 0, vblnk = 0;
    logic        select_mode = 0, cursor_en = 1, mouse_left = 0;
    logic [10:0] hcount_out;
    logic [9:0]  vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;
    logic [1:0]  mode_out;

    cursor_overlay_pipe dut (
        .clk(clk), .rst(rst), .xpos(xpos), .ypos(ypos), .hcount(hcount), .vcount(vcount),
        .hsync(hsync), .vsync(vsync), .hblnk(hblnk), .vblnk(vblnk), .rgb_in(rgb_in),
        .select_mode(select_mode), .cursor_en(cursor_en), .mouse_left(mouse_left),
        .hcount_out(hcount_out), .vcount_out(vcount_out), .hsync_out(hsync_out),
        .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out), .mode_out(mode_out)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    logic mon_en = 1'b0;
    logic [36:0] exp_q[$];

    // Frame-level reference state
    int   m_lx = 0, m_ly = 0, m_mode = 0, m_cnt = 0;
    logic m_pending = 0, m_vs_prev = 0, m_mouse_prev = 0;

    function automatic logic [11:0] ref_pix(int h, int v, logic [11:0] bg, logic blank);
        int dx, dy, ax, ay;
        logic ol, fl, sc;
        dx = h - m_lx;
        dy = v - m_ly;
        if (blank || m_mode == 2) return bg;
        if (m_mode == 0) begin
            if (dx < 0 || dy < 0) return bg;
            ol = (dx == 0 && dy <= A_H) || (dx == dy && dy <= A_W)
              || (dy == A_W && dx >= A_H - A_W && dx <= A_W)
              || (dx + dy == A_H && dx >= 1 && dy > A_W);
            if (ol) return 12'h000;
            fl = dx >= 1 && dy > dx && (dy < A_W || dx + dy < A_H);
            return fl ? 12'hfff : bg;
        end
        ax = (dx < 0) ? -dx : dx;
        ay = (dy < 0) ? -dy : dy;
        sc = (dx == 0 && dy == 0) || (dy == 0 && ax > GAPW && ax <= GAPW + ARM)
          || (dx == 0 && ay > GAPW && ay <= GAPW + ARM);
        return sc ? ((m_cnt > 0) ? 12'hf00 : 12'h000) : bg;
    endfunction

    // One pixel clock: drive inputs, advance the model, queue the expected output.
    task automatic cycle(input int h, input int v, input logic hs, input logic vs,
                         input logic hb, input logic vb, input logic [11:0] bg,
                         input logic use_exp, input logic [11:0] exp_c);
        logic boundary, rise;
        logic [11:0] e;
        hcount = 11'(h); vcount = 10'(v); hsync = hs; vsync = vs;
        hblnk = hb; vblnk = vb; rgb_in = bg;
        boundary = vs && !m_vs_prev;
        rise = mouse_left && !m_mouse_prev;
        if (boundary) begin
            m_lx = int'(xpos);
            m_ly = int'(ypos);
            m_mode = !cursor_en ? 2 : (select_mode && int'(xpos) < CHX) ? 1 : 0;
            if (m_pending || rise) m_cnt = FLASH;
            else if (m_cnt > 0) m_cnt = m_cnt - 1;
            m_pending = 1'b0;
        end else if (rise) begin
            m_pending = 1'b1;
        end
        m_vs_prev = vs;
        m_mouse_prev = mouse_left;
        e = use_exp ? exp_c : ref_pix(h, v, bg, hb | vb);
        exp_q.push_back({11'(h), 10'(v), hs, vs, hb, vb, e});
        @(posedge clk);
        #1;
        if (boundary) begin
            total++;
            if (mode_out !== 2'(m_mode)) begin
                bad++;
                $display("FAIL mode_out: got %0d want %0d", mode_out, m_mode);
            end
        end
        @(negedge clk);
    endtask

    task automatic pix(input int h, input int v, input logic [11:0] bg);
        cycle(h, v, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, bg, 1'b0, 12'h0);
    endtask

    task automatic pixe(input int h, input int v, input logic [11:0] bg, input logic [11:0] e);
        cycle(h, v, 1'b0, 1'b0, 1'b0, 1'b0, bg, 1'b1, e);
    endtask

    // Vertical blank with a vsync rising edge; optional click on the boundary cycle.
    task automatic frame(input logic click_at_edge);
        mouse_left = 1'b0;
        cycle(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h123, 1'b0, 12'h0);
        mouse_left = click_at_edge;
        cycle(0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 12'h456, 1'b0, 12'h0);
        mouse_left = 1'b0;
        cycle(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h789, 1'b0, 12'h0);
    endtask

    initial begin : monitor
        logic [36:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && exp_q.size() >= 2) begin
                e = exp_q.pop_front();
                total++;
                if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} !== e[36:12]) begin
                    bad++;
                    $display("FAIL timing: got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b want h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b",
                             hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
                             e[36:26], e[25:16], e[15], e[14], e[13], e[12]);
                end
                total++;
                if (rgb_out !== e[11:0]) begin
                    bad++;
                    $display("FAIL rgb at h=%0d v=%0d mode=%0d: got %h want %h",
                             e[36:26], e[25:16], mode_out, rgb_out, e[11:0]);
                end
            end
        end
    end

    initial begin : stim
        // Reset with busy inputs: every output must read zero.
        hcount = 11'd5; vcount = 10'd7; hsync = 1; vsync = 1; hblnk = 1; vblnk = 1;
        rgb_in = 12'hfff; mouse_left = 0;
        @(posedge clk);
        #1;
        total++;
        if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out, mode_out} !== '0) begin
            bad++;
            $display("FAIL reset: got h=%0d v=%0d rgb=%h mode=%0d want all 0",
                     hcount_out, vcount_out, rgb_out, mode_out);
        end
        @(negedge clk);
        rst = 1'b0;
        vsync = 0;
        mon_en = 1'b1;

        // Before any boundary: arrow at the origin.
        pixe(0, 0, 12'h0aa, 12'h000);
        cycle(5, 3, 1'b1, 1'b0, 1'b0, 1'b0, 12'h0bb, 1'b0, 12'h0);

        // Arrow at (100,50), then a mid-frame position change that must not take effect.
        xpos = 12'd100; ypos = 12'd50; select_mode = 0; cursor_en = 1;
        frame(1'b0);
        pixe(100, 50, 12'h5a5, 12'h000);
        pixe(103, 58, 12'h5a5, 12'hfff);
        pixe(105, 62, 12'h5a5, 12'h000);
        pixe(101, 66, 12'h5a5, 12'h000);
        pixe(106, 50, 12'h5a5, 12'h5a5);
        xpos = 12'd300;
        pixe(100, 50, 12'h321, 12'h000);
        pixe(300, 50, 12'h321, 12'h321);
        cycle(100, 50, 1'b0, 1'b0, 1'b1, 1'b0, 12'h3c3, 1'b1, 12'h3c3);
        frame(1'b0);
        pixe(300, 50, 12'h321, 12'h000);
        pixe(100, 50, 12'h321, 12'h321);

        // Scope allowed left of the threshold, refused right of it.
        select_mode = 1; xpos = 12'd700;
        frame(1'b0);
        pixe(698, 50, 12'h777, 12'h000);
        pixe(699, 50, 12'h777, 12'h777);
        xpos = 12'd800;
        frame(1'b0);
        pixe(800, 50, 12'h777, 12'h000);

        // Click flash: mid-frame click, then a click on the boundary cycle itself.
        xpos = 12'd200;
        frame(1'b0);
        mouse_left = 1; pixe(202, 50, 12'h111, 12'h000);
        mouse_left = 0; pixe(202, 50, 12'h111, 12'h000);
        for (int f = 1; f <= 9; f++) begin
            frame(1'b0);
            pixe(202, 50, 12'h111, (f <= FLASH) ? 12'hf00 : 12'h000);
            pixe(200, 52, 12'h111, (f <= FLASH) ? 12'hf00 : 12'h000);
        end
        frame(1'b1);
        pixe(202, 50, 12'h111, 12'hf00);

        // Hidden cursor: plain passthrough.
        cursor_en = 0;
        frame(1'b0);
        pixe(200, 50, 12'h9a9, 12'h9a9);
        pixe(204, 50, 12'h9a9, 12'h9a9);

        // Random frames.
        for (int fr = 0; fr < 30; fr++) begin
            xpos = 12'($urandom_range(0, 1000));
            ypos = 12'($urandom_range(0, 600));
            select_mode = 1'($urandom_range(0, 1));
            cursor_en = ($urandom_range(0, 5) != 0);
            frame(1'($urandom_range(0, 3) == 0));
            for (int p = 0; p < 60; p++) begin
                int h, v;
                h = m_lx + int'($urandom_range(0, 30)) - 8;
                v = m_ly + int'($urandom_range(0, 30)) - 8;
                if (h < 0) h = 0;
                if (h > 2047) h = 2047;
                if (v < 0) v = 0;
                if (v > 1023) v = 1023;
                mouse_left = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 7) == 0)
                    cycle(h, v, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b1,
                          12'($urandom), 1'b0, 12'h0);
                else
                    pix(h, v, 12'($urandom));
            end
        end

        mouse_left = 0;
        for (int i = 0; i < 3; i++) pix(0, 0, 12'h000);
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
